obstacle_field_gen: RTL

//  Parametrised multi-obstacle generator for obstacle mode of the snake game; successor to the single-obstacle generator.

---
 rtl/obstacle_field_gen_pkg.sv | 13 +
 rtl/obstacle_field_gen_if.sv | 29 ++
 rtl/obstacle_field_gen_slot_array.sv | 42 ++++
 rtl/obstacle_field_gen.sv | 108 ++++++++++
 4 files changed

// File: rtl/obstacle_field_gen_pkg.sv
// obstacle_field_gen_pkg: shared types and constants for the obstacle field generator
package obstacle_field_gen_pkg;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;
  localparam int GRID_W = 16;
  localparam int GRID_H = 11;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;
endpackage

// File: rtl/obstacle_field_gen_if.sv
// obstacle_field_gen_if: game-side signals of the obstacle field generator
interface obstacle_field_gen_if #(
  parameter int NUM_OBS    = 4,
  parameter int MAX_LENGTH = 140
);
  localparam int CW = $clog2(NUM_OBS + 1);
  logic                        s_reset;
  logic                        enable;
  logic                        goodColl;
  logic [3:0]                  randX;
  logic [3:0]                  randY;
  logic [3:0]                  appleX;
  logic [3:0]                  appleY;
  logic [MAX_LENGTH-1:0][7:0]  body;
  logic [7:0]                  curr_length;
  logic [3:0]                  x;
  logic [3:0]                  y;
  logic                        obstacle;
  logic [CW-1:0]               obs_count;
  logic                        busy;
  modport master (
    output s_reset, enable, goodColl, randX, randY, appleX, appleY, body, curr_length, x, y,
    input  obstacle, obs_count, busy
  );
  modport slave (
    input  s_reset, enable, goodColl, randX, randY, appleX, appleY, body, curr_length, x, y,
    output obstacle, obs_count, busy
  );
endinterface

// File: rtl/obstacle_field_gen_slot_array.sv
// obstacle_field_gen_slot_array: obstacle slot registers with pixel and candidate match ports
module obstacle_field_gen_slot_array
  import obstacle_field_gen_pkg::*;
#(
  parameter int NUM_OBS = 4,
  parameter int PW      = 2,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [PW-1:0] wr_ptr,
  input  coord_t        wr_coord,
  input  coord_t        pix,
  output logic          pix_hit,
  input  coord_t        cand,
  input  logic [PW-1:0] excl,
  output logic          cand_hit,
  output logic [CW-1:0] count
);
  coord_t             slot [NUM_OBS];
  logic [NUM_OBS-1:0] valid;
  // slot storage; the slot about to be overwritten is masked from candidate matching
  always_ff @(posedge clk) begin
    if (clr) valid <= '0;
    else if (we) begin
      slot[wr_ptr]  <= wr_coord;
      valid[wr_ptr] <= 1'b1;
    end
  end
  // match reduction over valid slots and population count
  always_comb begin
    pix_hit  = 1'b0;
    cand_hit = 1'b0;
    count    = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      pix_hit  = pix_hit | (valid[i] && slot[i] == pix);
      cand_hit = cand_hit | (valid[i] && slot[i] == cand && PW'(i) != excl);
      count    = count + CW'(valid[i]);
    end
  end
endmodule

// File: rtl/obstacle_field_gen.sv
// obstacle_field_gen: places obstacles at random free cells on each apple eaten
module obstacle_field_gen
  import obstacle_field_gen_pkg::*;
#(
  parameter int NUM_OBS        = 4,
  parameter int MAX_LENGTH     = 140,
  parameter int X_MIN          = 1,
  parameter int X_MAX          = 14,
  parameter int Y_MIN          = 1,
  parameter int Y_MAX          = 9,
  parameter int MAX_RETRY      = 8,
  parameter int REPLACE_OLDEST = 1
) (
  input logic                 clk,
  input logic                 reset,
  obstacle_field_gen_if.slave bus
);
  localparam int PW = NUM_OBS > 1 ? $clog2(NUM_OBS) : 1;
  localparam int CW = $clog2(NUM_OBS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [3:0] XL = 4'(X_MIN);
  localparam logic [3:0] XH = 4'(X_MAX);
  localparam logic [3:0] YL = 4'(Y_MIN);
  localparam logic [3:0] YH = 4'(Y_MAX);
  logic [1:0]    state;
  logic [PW-1:0] wr_ptr;
  logic [7:0]    idx;
  logic [RW-1:0] retry;
  logic          pending;
  coord_t        cand;
  coord_t        rnd;
  coord_t        pix;
  logic          clr;
  logic          pix_hit;
  logic          cand_hit;
  logic [CW-1:0] count;
  logic          full;
  logic          rnd_bad;
  logic          body_hit;
  logic          chk_done;
  logic          retry_last;
  logic          we;
  assign clr        = reset | bus.s_reset;
  assign rnd        = coord_t'({bus.randX, bus.randY});
  assign pix        = coord_t'({bus.x, bus.y});
  assign full       = count == CW'(NUM_OBS);
  assign rnd_bad    = rnd.x < XL || rnd.x > XH || rnd.y < YL || rnd.y > YH ||
                      (rnd.x == bus.appleX && rnd.y == bus.appleY) || cand_hit;
  assign body_hit   = idx < bus.curr_length && bus.body[idx] == cand;
  assign chk_done   = bus.curr_length == 8'd0 || idx >= bus.curr_length - 8'd1;
  assign retry_last = retry == RW'(MAX_RETRY - 1);
  assign we         = state == ST_COMMIT && bus.enable && !clr;
  obstacle_field_gen_slot_array #(.NUM_OBS(NUM_OBS), .PW(PW), .CW(CW)) u_slots (
    .clk      (clk),
    .clr      (clr),
    .we       (we),
    .wr_ptr   (wr_ptr),
    .wr_coord (cand),
    .pix      (pix),
    .pix_hit  (pix_hit),
    .cand     (rnd),
    .excl     (wr_ptr),
    .cand_hit (cand_hit),
    .count    (count)
  );
  // placement FSM: sample a candidate, scan the body one entry per cycle, then commit
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      pending <= 1'b0;
      retry   <= '0;
      idx     <= '0;
      cand    <= '0;
    end else if (!bus.enable) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
    end else begin
      if (state != ST_IDLE && bus.goodColl) pending <= 1'b1;
      case (state)
        ST_IDLE: if (bus.goodColl || pending) begin
          pending <= 1'b0;
          retry   <= '0;
          if (!full || REPLACE_OLDEST != 0) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          cand <= rnd;
          idx  <= '0;
          if (!rnd_bad) state <= ST_CHECK;
          else if (retry_last) state <= ST_IDLE;
          else retry <= retry + 1'b1;
        end
        ST_CHECK: if (body_hit) begin
          state <= retry_last ? ST_IDLE : ST_SAMPLE;
          retry <= retry + 1'b1;
        end else if (chk_done) state <= ST_COMMIT;
        else idx <= idx + 8'd1;
        default: begin
          state  <= ST_IDLE;
          wr_ptr <= wr_ptr == PW'(NUM_OBS - 1) ? '0 : wr_ptr + 1'b1;
        end
      endcase
    end
  end
  assign bus.obstacle  = bus.enable & pix_hit;
  assign bus.obs_count = count;
  assign bus.busy      = state != ST_IDLE;
endmodule
